// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the word PC, issues req/ack reads to
// instruction memory and buffers each returned word toward decode.
module fetch_sequencer #(
  parameter int                ADDR_W   = 5,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        state_dbg
);

  // Handshakes: mem_req stays high with mem_addr frozen until the cycle
  // mem_ack is sampled high; inst/inst_pc hold while inst_valid=1 and
  // inst_ready=0, and transfer on a clock edge where both are high.

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]        state;
  logic              drop;
  logic [ADDR_W-1:0] target;

  // Address of the next request if a new one is launched this cycle.
  assign target    = redirect_valid ? redirect_pc : pc;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          mem_req  <= 1'b1;
          mem_addr <= target;
          pc       <= target;
        end
        REQ: begin
          if (mem_ack) begin
            if (!drop && !redirect_valid) begin
              state      <= HOLD;
              mem_req    <= 1'b0;
              inst       <= mem_rdata;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              pc         <= pc + 1'b1;
            end else begin
              // Stale or flushed data: reissue to the current (or new) pc.
              drop     <= 1'b0;
              mem_addr <= target;
              pc       <= target;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
            pc   <= redirect_pc;
          end
        end
        HOLD: begin
          if (redirect_valid || inst_ready) begin
            state      <= REQ;
            mem_req    <= 1'b1;
            inst_valid <= 1'b0;
            mem_addr   <= target;
            pc         <= target;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
